// File: rtl/image_sprite_loader_if.sv
// Bundle of the sprite loader's control, byte-stream and BRAM write-port signals.
// The slave modport is the loader and the master modport is the host/bench side.
interface image_sprite_loader_if #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256
) ();
  localparam int unsigned ImgAw = $clog2(WIDTH * HEIGHT * 2);

  logic             start_in;
  logic             page_in;
  logic [7:0]       byte_in;
  logic             byte_valid_in;
  logic             byte_ready_out;
  logic [7:0]       palette_addr_out;
  logic [23:0]      palette_data_out;
  logic             palette_we_out;
  logic [ImgAw-1:0] image_addr_out;
  logic [7:0]       image_data_out;
  logic             image_we_out;
  logic             busy_out;
  logic             done_out;
  logic             error_out;

  modport slave (
    input  start_in, page_in, byte_in, byte_valid_in,
    output byte_ready_out, palette_addr_out, palette_data_out, palette_we_out,
    output image_addr_out, image_data_out, image_we_out, busy_out, done_out, error_out
  );

  modport master (
    output start_in, page_in, byte_in, byte_valid_in,
    input  byte_ready_out, palette_addr_out, palette_data_out, palette_we_out,
    input  image_addr_out, image_data_out, image_we_out, busy_out, done_out, error_out
  );
endinterface

// File: rtl/image_sprite_loader.sv
// Sprite store writer: loads a 256-entry {R,G,B} palette then one image page of
// 8-bit palette indices from a valid/ready byte stream into the BRAM write ports.
// Optional trailing checksum byte: define IMAGE_SPRITE_LOADER_CHECKSUM_EN.
module image_sprite_loader #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned HEIGHT    = 256,
  parameter int unsigned PAL_DEPTH = 256
) (
  input logic                  pixel_clk_in,
  input logic                  rst_in,
  image_sprite_loader_if.slave bus
);
  localparam int unsigned Pix     = WIDTH * HEIGHT;
  localparam int unsigned ImgAw   = $clog2(Pix * 2);
  localparam int unsigned PixCw   = $clog2(Pix) + 1;
  localparam int unsigned PalCw   = $clog2(PAL_DEPTH) + 1;
  localparam bit          PixPow2 = ((Pix & (Pix - 1)) == 0);

  typedef enum logic [2:0] {StIdle, StPal, StImg, StChk, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       red_q, red_d, grn_q, grn_d;
  logic [PalCw-1:0] entry_q, entry_d;
  logic [PixCw-1:0] pix_q, pix_d;
  logic             page_q, page_d;
  logic [7:0]       sum_q, sum_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic             pal_we_q, pal_we_d, img_we_q, img_we_d;
  logic [7:0]       pal_addr_q, pal_addr_d;
  logic [23:0]      pal_data_q, pal_data_d;
  logic [ImgAw-1:0] img_addr_q, img_addr_d, pix_addr;
  logic [7:0]       img_data_q, img_data_d;
  logic             accept;

  assign accept = bus.byte_valid_in & ready_q;

  // Page offset: plain concatenation when the page size is a power of two.
  always_comb begin
    if (PixPow2) begin
      pix_addr = {page_q, pix_q[ImgAw-2:0]};
    end else begin
      pix_addr = ImgAw'(pix_q) + (page_q ? ImgAw'(Pix) : '0);
    end
  end

  // Next-state, counters, byte assembly and registered write-port values.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    red_d      = red_q;
    grn_d      = grn_q;
    entry_d    = entry_q;
    pix_d      = pix_q;
    page_d     = page_q;
    sum_d      = sum_q;
    err_d      = err_q;
    pal_we_d   = 1'b0;
    img_we_d   = 1'b0;
    pal_addr_d = pal_addr_q;
    pal_data_d = pal_data_q;
    img_addr_d = img_addr_q;
    img_data_d = img_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_in) begin
          page_d  = bus.page_in;
          phase_d = '0;
          red_d   = '0;
          grn_d   = '0;
          entry_d = '0;
          pix_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
          state_d = StPal;
        end
      end
      StPal: begin
        if (accept) begin
          sum_d = sum_q + bus.byte_in;
          unique case (phase_q)
            2'd0: begin
              red_d   = bus.byte_in;
              phase_d = 2'd1;
            end
            2'd1: begin
              grn_d   = bus.byte_in;
              phase_d = 2'd2;
            end
            default: begin
              pal_we_d   = 1'b1;
              pal_addr_d = 8'(entry_q);
              pal_data_d = {red_q, grn_q, bus.byte_in};
              phase_d    = 2'd0;
              entry_d    = entry_q + 1'b1;
              if (entry_q == PalCw'(PAL_DEPTH - 1)) state_d = StImg;
            end
          endcase
        end
      end
      StImg: begin
        if (accept) begin
          sum_d      = sum_q + bus.byte_in;
          img_we_d   = 1'b1;
          img_addr_d = pix_addr;
          img_data_d = bus.byte_in;
          pix_d      = pix_q + 1'b1;
          if (pix_q == PixCw'(Pix - 1)) begin
`ifdef IMAGE_SPRITE_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end
        end
      end
      StChk: begin
`ifdef IMAGE_SPRITE_LOADER_CHECKSUM_EN
        if (accept) begin
          if (bus.byte_in != sum_q) err_d = 1'b1;
          state_d = StDone;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Status flags are decoded from the next state so they register alongside it.
    ready_d = (state_d == StPal) || (state_d == StImg) || (state_d == StChk);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  // State and datapath registers; reset abandons any partial triplet or load.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      red_q      <= '0;
      grn_q      <= '0;
      entry_q    <= '0;
      pix_q      <= '0;
      page_q     <= 1'b0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pal_we_q   <= 1'b0;
      img_we_q   <= 1'b0;
      pal_addr_q <= '0;
      pal_data_q <= '0;
      img_addr_q <= '0;
      img_data_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      entry_q    <= entry_d;
      pix_q      <= pix_d;
      page_q     <= page_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pal_we_q   <= pal_we_d;
      img_we_q   <= img_we_d;
      pal_addr_q <= pal_addr_d;
      pal_data_q <= pal_data_d;
      img_addr_q <= img_addr_d;
      img_data_q <= img_data_d;
    end
  end

  assign bus.byte_ready_out   = ready_q;
  assign bus.busy_out         = busy_q;
  assign bus.done_out         = done_q;
  assign bus.palette_we_out   = pal_we_q;
  assign bus.palette_addr_out = pal_addr_q;
  assign bus.palette_data_out = pal_data_q;
  assign bus.image_we_out     = img_we_q;
  assign bus.image_addr_out   = img_addr_q;
  assign bus.image_data_out   = img_data_q;
`ifdef IMAGE_SPRITE_LOADER_CHECKSUM_EN
  assign bus.error_out        = err_q;
`else
  assign bus.error_out        = 1'b0;
`endif
endmodule

// File: tb/tb_image_sprite_loader.sv
// Self-checking bench for image_sprite_loader with a 4x2 sprite.
// Write strobes are checked against a scoreboard filled when bytes are driven.
module tb_image_sprite_loader;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned AW = $clog2(W * H * 2);

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   pal_cnt = 0;
  int   img_cnt = 0;
  logic [7:0] sum_m;
  logic [31:0]     pal_q[$];
  logic [AW+7:0]   img_q[$];

  image_sprite_loader_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  image_sprite_loader #(.WIDTH(W), .HEIGHT(H), .PAL_DEPTH(256)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached, required completion");
    $fatal(1);
  end

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.palette_we_out) begin
        logic [31:0] exp_p;
        pal_cnt++;
        checks++;
        if (pal_q.size() == 0) begin
          errors++;
          $display("FAIL pal_write: unexpected strobe addr %0d data %06h",
                   bus.palette_addr_out, bus.palette_data_out);
        end else begin
          exp_p = pal_q.pop_front();
          if ({bus.palette_addr_out, bus.palette_data_out} !== exp_p) begin
            errors++;
            $display("FAIL pal_write: got %0d/%06h required %0d/%06h",
                     bus.palette_addr_out, bus.palette_data_out, exp_p[31:24], exp_p[23:0]);
          end
        end
      end
      if (bus.image_we_out) begin
        logic [AW+7:0] exp_i;
        img_cnt++;
        checks++;
        if (img_q.size() == 0) begin
          errors++;
          $display("FAIL img_write: unexpected strobe addr %0d data %02h",
                   bus.image_addr_out, bus.image_data_out);
        end else begin
          exp_i = img_q.pop_front();
          if ({bus.image_addr_out, bus.image_data_out} !== exp_i) begin
            errors++;
            $display("FAIL img_write: got %0d/%02h required %0d/%02h",
                     bus.image_addr_out, bus.image_data_out, exp_i[AW+7:8], exp_i[7:0]);
          end
        end
      end
    end
  end

  function automatic logic [23:0] pal_val(input int e);
    logic [7:0] x;
    x = 8'(e);
    if (e == 0) return 24'h112233;
    return {x, x ^ 8'hA5, x + 8'd3};
  endfunction

  // Enters and leaves at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.byte_valid_in = 1'b0;
      @(negedge clk);
    end
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    n = 0;
    while (!bus.byte_ready_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_byte: ready stayed %0b required 1", bus.byte_ready_out);
    end
    @(negedge clk);
    sum_m = sum_m + b;
    bus.byte_valid_in = 1'b0;
  endtask

  task automatic start_load(input logic page);
    bus.start_in = 1'b1;
    bus.page_in  = page;
    @(negedge clk);
    bus.start_in = 1'b0;
    sum_m   = 8'h00;
    pal_cnt = 0;
    img_cnt = 0;
    checks++;
    if (bus.busy_out !== 1'b1 || bus.byte_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL start: busy %0b ready %0b required 1 1", bus.busy_out, bus.byte_ready_out);
    end
  endtask

  task automatic send_entry(input int e, input bit stall);
    logic [23:0] v;
    v = pal_val(e);
    pal_q.push_back({8'(e), v});
    send_byte(v[23:16], stall);
    send_byte(v[15:8], stall);
    send_byte(v[7:0], stall);
  endtask

  task automatic run_load(input logic page, input bit stall, input bit midstart,
                          input bit bad_sum, input bit start_at_done);
    int n;
    logic [7:0] d;
    start_load(page);
    for (int e = 0; e < 256; e++) send_entry(e, stall);
    for (int p = 0; p < int'(W * H); p++) begin
      d = 8'(p * 17) ^ {page, 7'h05};
      img_q.push_back({AW'(int'(page) * int'(W * H) + p), d});
      if (midstart && p == 4) begin
        bus.start_in = 1'b1;
        bus.page_in  = ~page;
      end
      send_byte(d, stall);
      bus.start_in = 1'b0;
      bus.page_in  = page;
    end
`ifdef IMAGE_SPRITE_LOADER_CHECKSUM_EN
    send_byte(bad_sum ? sum_m + 8'd1 : sum_m, 1'b0);
`endif
    n = 0;
    while (!bus.done_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.done_out !== 1'b1 || bus.busy_out !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done %0b busy %0b required 1 1", bus.done_out, bus.busy_out);
    end
    if (start_at_done) bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    checks++;
    if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL done_end: done %0b busy %0b required 0 0", bus.done_out, bus.busy_out);
    end
    checks++;
    if (pal_cnt != 256 || img_cnt != int'(W * H) || pal_q.size() != 0 || img_q.size() != 0)
    begin
      errors++;
      $display("FAIL strobe_count: pal %0d img %0d left %0d/%0d required 256 %0d 0/0",
               pal_cnt, img_cnt, pal_q.size(), img_q.size(), W * H);
    end
`ifdef IMAGE_SPRITE_LOADER_CHECKSUM_EN
    checks++;
    if (bus.error_out !== bad_sum) begin
      errors++;
      $display("FAIL error_flag: got %0b required %0b", bus.error_out, bad_sum);
    end
`else
    checks++;
    if (bus.error_out !== 1'b0) begin
      errors++;
      $display("FAIL error_flag: got %0b required 0", bus.error_out);
    end
`endif
    if (start_at_done) begin
      @(negedge clk);
      checks++;
      if (bus.busy_out !== 1'b0 || bus.byte_ready_out !== 1'b0) begin
        errors++;
        $display("FAIL start_at_done: busy %0b ready %0b required 0 0",
                 bus.busy_out, bus.byte_ready_out);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.byte_ready_out, bus.palette_addr_out, bus.palette_data_out, bus.palette_we_out,
         bus.image_addr_out, bus.image_data_out, bus.image_we_out, bus.busy_out,
         bus.done_out, bus.error_out} !== '0) begin
      errors++;
      $display("FAIL %s: outputs ready %0b pa %0d pd %06h pwe %0b ia %0d id %02h iwe %0b busy %0b done %0b err %0b required all 0",
               name, bus.byte_ready_out, bus.palette_addr_out, bus.palette_data_out,
               bus.palette_we_out, bus.image_addr_out, bus.image_data_out, bus.image_we_out,
               bus.busy_out, bus.done_out, bus.error_out);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    bus.byte_valid_in = 1'b1;
    bus.byte_in       = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.byte_ready_out !== 1'b0 || bus.busy_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid: ready %0b busy %0b required 0 0",
                 bus.byte_ready_out, bus.busy_out);
      end
    end
    bus.byte_valid_in = 1'b0;
    checks++;
    if (pal_cnt != 0 || img_cnt != 0) begin
      errors++;
      $display("FAIL idle_strobes: pal %0d img %0d required 0 0", pal_cnt, img_cnt);
    end
  endtask

  task automatic test_back_to_back;
    run_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_page1;
    run_load(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_midstart;
    run_load(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [23:0] v;
    start_load(1'b0);
    for (int e = 0; e < 5; e++) send_entry(e, 1'b0);
    v = pal_val(5);
    send_byte(v[23:16], 1'b0);
    send_byte(v[15:8], 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    check_all_zero("reset_mid_hold");
    checks++;
    if (pal_cnt != 5 || pal_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_strobes: pal %0d left %0d required 5 0", pal_cnt, pal_q.size());
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef IMAGE_SPRITE_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    run_load(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.error_out !== 1'b1) begin
      errors++;
      $display("FAIL error_hold: got %0b required 1", bus.error_out);
    end
    start_load(1'b0);
    checks++;
    if (bus.error_out !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got %0b required 0", bus.error_out);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst_n             = 1'b0;
    bus.start_in      = 1'b0;
    bus.page_in       = 1'b0;
    bus.byte_in       = 8'h00;
    bus.byte_valid_in = 1'b0;
    sum_m             = 8'h00;
    test_reset();
    test_back_to_back();
    test_stall_page1();
    test_midstart();
    test_reset_mid();
`ifdef IMAGE_SPRITE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
